pcie_ingress_ctrl: RTL and testbench

Upstream feeder for the PCIE transaction block. It takes a bursty host word stream over a valid/ready handshake and holds it in a small skid buffer. It then issues push / data_in_principal into the main FIFO one word per cycle, honouring Pausa_MF and the init/hold window. It also keeps per-VC push counters for the bench and the control FSM.

---
 rtl/pcie_pkg.sv | 20 ++
 rtl/ingress_skid_buf.sv | 48 ++++
 rtl/pcie_ingress_ctrl.sv | 122 ++++++++++++
 tb/tb_pcie_ingress_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIE ingress controller: word layout and
// control FSM state encoding.
package pcie_pkg;

  localparam int DATA_W   = 6;
  localparam int VC_BIT   = 5;
  localparam int DEST_BIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PAUSED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic logic word_vc(input logic [DATA_W-1:0] w);
    return w[VC_BIT];
  endfunction

endpackage

// File: rtl/ingress_skid_buf.sv
// Circular skid buffer between the host handshake and the issue stage.
// count runs 0..DEPTH so a full buffer is distinguishable from empty.
module ingress_skid_buf #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign head = mem[rd_ptr];

  // Pointer/count update; storage itself needs no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_ingress_ctrl.sv
// Ingress feeder: accepts host words into a skid buffer and issues them
// one per cycle into the main FIFO under pause/hold control.
module pcie_ingress_ctrl
  import pcie_pkg::*;
#(
  parameter int DATA_W     = pcie_pkg::DATA_W,
  parameter int SKID_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              pause_in,
  output logic              push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt_vc0,
  output logic [CNT_W-1:0]  cnt_vc1,
  output logic              busy,
  output logic              ovf_err
);

  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(SKID_DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = '0;
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] VC_MAX   = '1;
  localparam logic [CNT_W-1:0] VC_ONE   = CNT_W'(1);

  state_t            state;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_nxt;
  logic [DATA_W-1:0] head;
  logic              wr_en;
  logic              issue;

  assign in_ready = (count < DEPTH_C) & ~reset_L;
  assign wr_en    = in_valid & in_ready;
  assign issue    = (state == SEND) & (count != CNT_ZERO) & ~pause_in & ~hold;
  assign busy     = (count != CNT_ZERO) | push_out;

  ingress_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH),
    .PTR_W  (PTR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (reset_L),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (issue),
    .head    (head),
    .count   (count)
  );

  // Occupancy after this edge; lets IDLE->SEND follow a write without a bubble.
  always_comb begin
    count_nxt = count;
    if (wr_en & ~issue) begin
      count_nxt = count + CNT_ONE;
    end else if (issue & ~wr_en) begin
      count_nxt = count - CNT_ONE;
    end else begin
      count_nxt = count;
    end
  end

  // Control FSM, issue register, per-VC counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      state    <= IDLE;
      push_out <= 1'b0;
      data_out <= '0;
      cnt_vc0  <= '0;
      cnt_vc1  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      push_out <= issue;
      if (issue) begin
        data_out <= head;
      end
      if (in_valid & ~in_ready) begin
        ovf_err <= 1'b1;
      end
      if (push_out) begin
        if (word_vc(data_out)) begin
          if (cnt_vc1 != VC_MAX) cnt_vc1 <= cnt_vc1 + VC_ONE;
        end else begin
          if (cnt_vc0 != VC_MAX) cnt_vc0 <= cnt_vc0 + VC_ONE;
        end
      end
      // hold is checked first everywhere so it overrides pause_in.
      case (state)
        IDLE: begin
          if (hold)                       state <= HOLD;
          else if (count_nxt != CNT_ZERO) state <= SEND;
          else                            state <= IDLE;
        end
        SEND: begin
          if (hold)                                state <= HOLD;
          else if (pause_in & (count != CNT_ZERO)) state <= PAUSED;
          else if (count_nxt == CNT_ZERO)          state <= IDLE;
          else                                     state <= SEND;
        end
        PAUSED: begin
          if (hold)           state <= HOLD;
          else if (~pause_in) state <= SEND;
          else                state <= PAUSED;
        end
        HOLD: begin
          if (hold)                       state <= HOLD;
          else if (count_nxt != CNT_ZERO) state <= SEND;
          else                            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_ingress_ctrl.sv
// Randomized bench with a queue-based reference model; a second instance
// built with 2-bit counters exercises counter saturation.
module tb_pcie_ingress_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       hold = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = 6'd0;
  logic       pause_in = 1'b0;
  logic       in_ready, push_out, busy, ovf_err;
  logic [5:0] data_out;
  logic [7:0] cnt_vc0, cnt_vc1;
  logic       s_in_ready, s_push_out, s_busy, s_ovf_err;
  logic [5:0] s_data_out;
  logic [1:0] s_cnt_vc0, s_cnt_vc1;

  always #5 clk = ~clk;

  pcie_ingress_ctrl dut (
    .clk(clk), .reset_L(reset_L), .hold(hold), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .pause_in(pause_in),
    .push_out(push_out), .data_out(data_out), .cnt_vc0(cnt_vc0),
    .cnt_vc1(cnt_vc1), .busy(busy), .ovf_err(ovf_err)
  );

  pcie_ingress_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_L(reset_L), .hold(hold), .in_valid(in_valid),
    .in_data(in_data), .in_ready(s_in_ready), .pause_in(pause_in),
    .push_out(s_push_out), .data_out(s_data_out), .cnt_vc0(s_cnt_vc0),
    .cnt_vc1(s_cnt_vc1), .busy(s_busy), .ovf_err(s_ovf_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: buffer contents as a queue, plus whether the block is
  // currently held or paused (each costs one restart cycle when released).
  logic [5:0] m_q[$];
  logic       m_push = 1'b0;
  logic [5:0] m_data = 6'd0;
  int         m_c0 = 0, m_c1 = 0, m_s0 = 0, m_s1 = 0;
  logic       m_ovf = 1'b0;
  logic       m_held = 1'b0;
  logic       m_paused = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic v, input logic [5:0] d, input logic p,
                            input logic h, input logic r);
    logic ne, iss, room;
    if (r) begin
      m_q.delete();
      m_push = 1'b0; m_data = 6'd0; m_ovf = 1'b0;
      m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
      m_held = 1'b0; m_paused = 1'b0;
    end else begin
      ne   = (m_q.size() != 0);
      room = (m_q.size() < 4);
      iss  = !m_held && !m_paused && !h && !p && ne;
      if (m_push) begin
        if (m_data[5]) begin
          if (m_c1 < 255) m_c1++;
          if (m_s1 < 3) m_s1++;
        end else begin
          if (m_c0 < 255) m_c0++;
          if (m_s0 < 3) m_s0++;
        end
      end
      m_paused = !h && (m_paused ? p : (!m_held && p && ne));
      m_held   = h;
      if (v && !room) m_ovf = 1'b1;
      m_push = iss;
      if (iss) m_data = m_q.pop_front();
      if (v && room) m_q.push_back(d);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, compare outputs.
  task automatic cycle(input logic v, input logic [5:0] d, input logic p,
                       input logic h, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; pause_in = p; hold = h; reset_L = r;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < 4) && !r});
    model_step(v, d, p, h, r);
    @(posedge clk);
    #1;
    chk("push_out", {31'd0, push_out}, {31'd0, m_push});
    chk("data_out", {26'd0, data_out}, {26'd0, m_data});
    chk("busy", {31'd0, busy}, {31'd0, (m_q.size() != 0) || m_push});
    chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
    chk("cnt_vc0", {24'd0, cnt_vc0}, m_c0);
    chk("cnt_vc1", {24'd0, cnt_vc1}, m_c1);
    chk("sat_cnt_vc0", {30'd0, s_cnt_vc0}, m_s0);
    chk("sat_cnt_vc1", {30'd0, s_cnt_vc1}, m_s1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset mid-burst: three words loaded under hold, then reset.
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'(i + 1), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_push", {31'd0, push_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_vc0, cnt_vc1}, 32'd0);
    idle(1);
    chk("rst_ready_after", {31'd0, in_ready}, 32'd1);

    // Back-to-back issue: 0x25, 0x0A, 0x31.
    cycle(1'b1, 6'h25, 1'b0, 1'b0, 1'b0);
    chk("b2b_lat", {31'd0, push_out}, 32'd0);
    cycle(1'b1, 6'h0A, 1'b0, 1'b0, 1'b0);
    chk("b2b_d0", {25'd0, push_out, data_out}, {25'd0, 1'b1, 6'h25});
    cycle(1'b1, 6'h31, 1'b0, 1'b0, 1'b0);
    chk("b2b_d1", {25'd0, push_out, data_out}, {25'd0, 1'b1, 6'h0A});
    idle(1);
    chk("b2b_d2", {25'd0, push_out, data_out}, {25'd0, 1'b1, 6'h31});
    idle(3);
    chk("b2b_vc1", {24'd0, cnt_vc1}, 32'd2);
    chk("b2b_vc0", {24'd0, cnt_vc0}, 32'd1);

    // Pause with four words buffered, then release and drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(8'h10 + i), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'h3F, 1'b1, 1'b0, 1'b0);
    idle(8);

    // Full plus overflow under hold.
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i), 1'b0, 1'b1, 1'b0);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 6'h2A, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", {31'd0, ovf_err}, 32'd1);
    idle(8);
    chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

    // Continuous write with issue active; occupancy stays level.
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 6'(i * 5), 1'b0, 1'b0, 1'b0);
    idle(6);

    // Counter saturation on the 2-bit build: five VC0 pushes.
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'(i), 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("sat_vc0", {30'd0, s_cnt_vc0}, 32'd3);
    chk("sat_vc1", {30'd0, s_cnt_vc1}, 32'd0);
    chk("full_vc0", {24'd0, cnt_vc0}, 32'd5);

    // Randomized phases with varying traffic/pause/hold density.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        cycle(($urandom_range(0, 9) < 3 + 2 * ph) ? 1'b1 : 1'b0,
              6'($urandom_range(0, 63)),
              ($urandom_range(0, 9) < ph + 1) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) < ph) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
